// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the fetch PC, talks req/ack to instruction memory and fills the
// IF_ID register consumed by the decode stage. Redirects and the stall
// enable come back from decode.
// Optional feature: define BRANCH_DELAY_SLOT_EN to make the word fetched
// in the redirecting cycle a delivered delay slot instead of squashing it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic        PC_IF_ID_Write,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_ID,
  output logic        IF_ID_valid
);

  // RUN: fetch outstanding at fetchPc. HOLD: fetched word parked in the
  // buffer while decode stalls. KILL: wrong-path fetch draining.
  typedef enum logic [1:0] {RUN, HOLD, KILL} state_t;

  localparam logic [63:0] BUBBLE = {32'h0000_0000, NOP_INSTR};

  state_t      state_q, state_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] pendPc_q, pendPc_d;
  logic [31:0] buffer_q, buffer_d;
  logic [63:0] ifId_q, ifId_d;
  logic        valid_q, valid_d;
  logic        startup_q;
`ifdef BRANCH_DELAY_SLOT_EN
  logic        pendFlag_q, pendFlag_d;
  logic [31:0] nextPc;
`endif

  logic        ackEff;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pcPlus4;

  // An ack in the first cycle after reset belongs to the abandoned access.
  assign ackEff  = imem_ack & ~startup_q;
  assign redir   = (Z | J | JR) & PC_IF_ID_Write;
  assign target  = JR ? jr_target : (J ? jump_target : branch_target);
  assign pcPlus4 = fetchPc_q + 32'd4;

  assign imem_req    = ~rst & (state_q != HOLD);
  assign imem_addr   = fetchPc_q;
  assign IF_ID       = ifId_q;
  assign IF_ID_valid = valid_q;

  // State, PC and IF_ID registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetchPc_q  <= RESET_PC;
      pendPc_q   <= RESET_PC;
      buffer_q   <= NOP_INSTR;
      ifId_q     <= BUBBLE;
      valid_q    <= 1'b0;
      startup_q  <= 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
      pendFlag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetchPc_q  <= fetchPc_d;
      pendPc_q   <= pendPc_d;
      buffer_q   <= buffer_d;
      ifId_q     <= ifId_d;
      valid_q    <= valid_d;
      startup_q  <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pendFlag_q <= pendFlag_d;
`endif
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // Delay-slot flavour: the word in flight at a redirect is still delivered,
  // and the PC then jumps to the newest target (or the remembered one).
  always_comb begin
    state_d    = state_q;
    fetchPc_d  = fetchPc_q;
    pendPc_d   = pendPc_q;
    buffer_d   = buffer_q;
    ifId_d     = ifId_q;
    valid_d    = valid_q;
    pendFlag_d = pendFlag_q;
    nextPc     = redir ? target : (pendFlag_q ? pendPc_q : pcPlus4);
    case (state_q)
      RUN: begin
        if (PC_IF_ID_Write) begin
          if (ackEff) begin
            ifId_d     = {pcPlus4, imem_rdata};
            valid_d    = 1'b1;
            fetchPc_d  = nextPc;
            pendFlag_d = 1'b0;
          end else begin
            ifId_d  = BUBBLE;
            valid_d = 1'b0;
            if (redir) begin
              pendPc_d   = target;
              pendFlag_d = 1'b1;
            end
          end
        end else if (ackEff) begin
          buffer_d = imem_rdata;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (PC_IF_ID_Write) begin
          ifId_d     = {pcPlus4, buffer_q};
          valid_d    = 1'b1;
          fetchPc_d  = nextPc;
          pendFlag_d = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
`else
  // Squash flavour: any redirect bubbles IF_ID; a wrong-path fetch still
  // outstanding is drained in KILL before the target is fetched.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    pendPc_d  = pendPc_q;
    buffer_d  = buffer_q;
    ifId_d    = ifId_q;
    valid_d   = valid_q;
    case (state_q)
      RUN: begin
        if (redir) begin
          ifId_d  = BUBBLE;
          valid_d = 1'b0;
          if (ackEff) begin
            fetchPc_d = target;
          end else begin
            pendPc_d = target;
            state_d  = KILL;
          end
        end else if (PC_IF_ID_Write) begin
          if (ackEff) begin
            ifId_d    = {pcPlus4, imem_rdata};
            valid_d   = 1'b1;
            fetchPc_d = pcPlus4;
          end else begin
            ifId_d  = BUBBLE;
            valid_d = 1'b0;
          end
        end else if (ackEff) begin
          buffer_d = imem_rdata;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          ifId_d    = BUBBLE;
          valid_d   = 1'b0;
          fetchPc_d = target;
          state_d   = RUN;
        end else if (PC_IF_ID_Write) begin
          ifId_d    = {pcPlus4, buffer_q};
          valid_d   = 1'b1;
          fetchPc_d = pcPlus4;
          state_d   = RUN;
        end
      end
      KILL: begin
        if (PC_IF_ID_Write) begin
          ifId_d  = BUBBLE;
          valid_d = 1'b0;
          if (redir) pendPc_d = target;
        end
        if (ackEff) begin
          fetchPc_d = redir ? target : pendPc_q;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
`endif

endmodule
